// File: rtl/alu_seq_core_if.sv
// Handshake bundle between the instruction front-end, alu_seq_core and writeback.
// master = front-end/consumer side, slave = core side.
interface alu_seq_core_if #(
  parameter int OPW   = 16,
  parameter int CNT_W = 8
);
  logic [2*OPW-1:0] instruction;
  logic [3:0]       op;
  logic             in_valid;
  logic             ready;
  logic [2*OPW-1:0] result;
  logic [3:0]       flags;
  logic             err;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] op_cnt;

  modport master (
    output instruction, op, in_valid, res_ready,
    input  ready, result, flags, err, res_valid, op_cnt
  );

  modport slave (
    input  instruction, op, in_valid, res_ready,
    output ready, result, flags, err, res_valid, op_cnt
  );
endinterface

// File: rtl/alu_seq_core.sv
// Handshaked ALU core: single-cycle ops plus an optional iterative shift-add multiply.
// Define ALU_SEQ_MUL_EN to build the multiplier (opcode 8); otherwise opcode 8 is illegal.
module alu_seq_core #(
  parameter int OPW   = 16,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  alu_seq_core_if.slave bus
);
  localparam int SHW = $clog2(OPW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             res_valid_q, res_valid_d;
  logic [2*OPW-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

  logic [OPW-1:0]   a_s, b_s;
  logic [OPW:0]     sum_s, diff_s;
  logic [OPW-1:0]   alu_res_s;
  logic             alu_c_s, alu_v_s, alu_ill_s;

`ifdef ALU_SEQ_MUL_EN
  logic [2*OPW-1:0] mcand_q, mcand_d;
  logic [OPW-1:0]   mplier_q, mplier_d;
  logic [2*OPW-1:0] acc_q, acc_d;
  logic [2*OPW-1:0] acc_nxt_s;
  logic [SHW-1:0]   step_q, step_d;
`endif

  assign a_s = bus.instruction[OPW-1:0];
  assign b_s = bus.instruction[2*OPW-1:OPW];

  // Single-cycle datapath evaluated straight from the presented operands
  always_comb begin
    sum_s     = {1'b0, a_s} + {1'b0, b_s};
    diff_s    = {1'b0, a_s} - {1'b0, b_s};
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_ill_s = 1'b0;
    case (bus.op)
      4'd0: begin
        alu_res_s = sum_s[OPW-1:0];
        alu_c_s   = sum_s[OPW];
        alu_v_s   = (a_s[OPW-1] == b_s[OPW-1]) && (sum_s[OPW-1] != a_s[OPW-1]);
      end
      4'd1: begin
        alu_res_s = diff_s[OPW-1:0];
        alu_c_s   = diff_s[OPW];  // borrow out equals unsigned A<B
        alu_v_s   = (a_s[OPW-1] != b_s[OPW-1]) && (diff_s[OPW-1] != a_s[OPW-1]);
      end
      4'd2: alu_res_s = a_s & b_s;
      4'd3: alu_res_s = a_s | b_s;
      4'd4: alu_res_s = a_s ^ b_s;
      4'd5: alu_res_s = a_s << b_s[SHW-1:0];
      4'd6: alu_res_s = a_s >> b_s[SHW-1:0];
      4'd7: alu_res_s = a_s;
`ifdef ALU_SEQ_MUL_EN
      4'd8: alu_ill_s = 1'b0;
`endif
      default: alu_ill_s = 1'b1;
    endcase
  end

  // Next-state and output-register update for the IDLE/EXEC/DONE controller
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    err_d       = err_q;
    op_cnt_d    = op_cnt_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    step_d    = step_q;
    acc_nxt_s = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (!ready_q) begin
          ready_d = 1'b1;
        end else if (bus.in_valid) begin
          ready_d     = 1'b0;
          state_d     = DONE;
          res_valid_d = 1'b1;
          result_d    = {{OPW{1'b0}}, alu_res_s};
          flags_d     = alu_ill_s ? 4'b0000
                                  : {alu_v_s, alu_c_s, alu_res_s[OPW-1], (alu_res_s == '0)};
          err_d       = alu_ill_s;
`ifdef ALU_SEQ_MUL_EN
          if (bus.op == 4'd8) begin
            state_d     = EXEC;
            res_valid_d = 1'b0;
            result_d    = result_q;
            flags_d     = flags_q;
            err_d       = 1'b0;
            mcand_d     = {{OPW{1'b0}}, a_s};
            mplier_d    = b_s;
            acc_d       = '0;
            step_d      = '0;
          end else begin
            state_d = DONE;
          end
`endif
        end else begin
          ready_d = 1'b1;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      EXEC: begin
        acc_d    = acc_nxt_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + SHW'(1);
        // Always runs all OPW steps, even for zero operands
        if (step_q == SHW'(OPW - 1)) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          result_d    = acc_nxt_s;
          flags_d     = {2'b00, acc_nxt_s[2*OPW-1], (acc_nxt_s == '0)};
          err_d       = 1'b0;
        end else begin
          state_d = EXEC;
        end
      end
`endif
      DONE: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          ready_d     = 1'b1;
          op_cnt_d    = op_cnt_q + CNT_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
        ready_d     = 1'b0;
      end
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      err_q       <= 1'b0;
      op_cnt_q    <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      step_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      op_cnt_q    <= op_cnt_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
`endif
    end
  end

  assign bus.ready     = ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;
  assign bus.op_cnt    = op_cnt_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (OPW=16, CNT_W=8) against an arithmetic reference model.
module tb_alu_seq_core;
  logic clk;
  logic rst;
  int   ncmp;
  int   nfail;
  logic [7:0] exp_cnt;

  alu_seq_core_if #(.OPW(16), .CNT_W(8)) bus ();

  alu_seq_core #(.OPW(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [3:0]  flags;
    logic [31:0] result;
    int          lat;
  } exp_t;

  function automatic exp_t ref_model(input int op, input longint a, input longint b);
    exp_t   e;
    longint sa, sb, r;
    bit     wide;
    e = '0;
    e.lat = 1;
    wide = 1'b0;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    case (op)
      0: begin
        r = a + b;
        e.result   = 32'(r % 65536);
        e.flags[2] = (r > 65535);
        e.flags[3] = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      1: begin
        r = a - b + 65536;
        e.result   = 32'(r % 65536);
        e.flags[2] = (a < b);
        e.flags[3] = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      2: e.result = 32'(a & b);
      3: e.result = 32'(a | b);
      4: e.result = 32'(a ^ b);
      5: e.result = 32'((a * (64'd1 << (b % 16))) % 65536);
      6: e.result = 32'(a / (64'd1 << (b % 16)));
      7: e.result = 32'(a);
`ifdef ALU_SEQ_MUL_EN
      8: begin
        e.result = 32'(a * b);
        e.lat    = 17;
        wide     = 1'b1;
      end
`endif
      default: e.err = 1'b1;
    endcase
    if (!e.err) begin
      e.flags[1] = wide ? e.result[31] : e.result[15];
      e.flags[0] = wide ? (e.result == 32'd0) : (e.result[15:0] == 16'd0);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int hold);
    exp_t e;
    int   w;
    int   lat;
    logic [31:0] held_res;
    e = ref_model(int'(op), longint'(a), longint'(b));
    w = 0;
    while (bus.ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_before_op", 64'(bus.ready), 64'd1);
    bus.instruction = {b, a};
    bus.op          = op;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("ready_after_accept", 64'(bus.ready), 64'd0);
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency_op%0d", op), 64'(lat), 64'(e.lat));
    check($sformatf("result_op%0d_%h_%h", op, a, b), 64'(bus.result), 64'(e.result));
    check($sformatf("flags_op%0d_%h_%h", op, a, b), 64'(bus.flags), 64'(e.flags));
    check($sformatf("err_op%0d", op), 64'(bus.err), 64'(e.err));
    held_res = e.result;
    for (int i = 0; i < hold; i++) begin
      bus.instruction = 32'($urandom);
      bus.op          = 4'($urandom_range(7, 0));
      bus.in_valid    = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.res_valid), 64'd1);
      check("hold_result", 64'(bus.result), 64'(held_res));
      check("hold_ready", 64'(bus.ready), 64'd0);
      check("hold_cnt", 64'(bus.op_cnt), 64'(exp_cnt));
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    exp_cnt++;
    check("cnt_after_handshake", 64'(bus.op_cnt), 64'(exp_cnt));
    check("valid_after_handshake", 64'(bus.res_valid), 64'd0);
    check("ready_after_handshake", 64'(bus.ready), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(bus.ready), 64'd0);
    check({tag, "_valid"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'd0);
    check({tag, "_flags"}, 64'(bus.flags), 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
    check({tag, "_cnt"}, 64'(bus.op_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", ncmp);
    $fatal(1, "watchdog");
  end

  initial begin
    ncmp            = 0;
    nfail           = 0;
    exp_cnt         = 8'd0;
    rst             = 1'b1;
    bus.instruction = 32'd0;
    bus.op          = 4'd0;
    bus.in_valid    = 1'b0;
    bus.res_ready   = 1'b0;

    #12;
    check_all_zero("reset");
    #11 rst = 1'b0;
    #1;
    check("ready_low_before_edge", 64'(bus.ready), 64'd0);
    @(posedge clk); #1;
    check("ready_first_edge", 64'(bus.ready), 64'd1);

    do_op(4'd0, 16'hFFFF, 16'h0001, 0);
    check("plan_add_flags", 64'(bus.flags), 64'h5);
    do_op(4'd1, 16'h8000, 16'h0001, 0);
    check("plan_sub1_result", 64'(bus.result), 64'h7FFF);
    do_op(4'd1, 16'h0001, 16'h0002, 0);
    check("plan_sub2_flags", 64'(bus.flags), 64'h6);
    do_op(4'd8, 16'h1234, 16'h0010, 0);
    do_op(4'd8, 16'h0000, 16'hBEEF, 1);
    do_op(4'd8, 16'hFFFF, 16'hFFFF, 0);
    do_op(4'd5, 16'h0001, 16'h000F, 0);
    check("plan_shl_result", 64'(bus.result), 64'h8000);
    do_op(4'd6, 16'h8000, 16'h0004, 0);
    check("plan_shr_result", 64'(bus.result), 64'h0800);
    do_op(4'd5, 16'h1357, 16'h0010, 0);
    do_op(4'd4, 16'hAAAA, 16'h5555, 5);
    do_op(4'd12, 16'h1234, 16'h5678, 0);
    do_op(4'd7, 16'h0000, 16'h1111, 0);

    // Abort a multiply part way through execution
    while (bus.ready !== 1'b1) begin
      @(posedge clk); #1;
    end
    bus.instruction = {16'h0010, 16'h1234};
    bus.op          = 4'd8;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("abort");
    exp_cnt = 8'd0;
    #3 rst = 1'b0;
    #1;
    check("abort_ready_pre_edge", 64'(bus.ready), 64'd0);
    @(posedge clk); #1;
    check("abort_ready_edge", 64'(bus.ready), 64'd1);
    do_op(4'd0, 16'h0002, 16'h0003, 0);
    check("plan_add_after_abort", 64'(bus.result), 64'h5);

    for (int k = 0; k < 255; k++) begin
      do_op(4'($urandom_range(15, 0)), 16'($urandom), 16'($urandom),
            int'($urandom_range(2, 0)));
    end
    check("cnt_wrap", 64'(bus.op_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, handshaked successor to the fixed 16-bit processor datapath.
- Accepts one instruction word carrying two OPW-bit operands plus a 4-bit opcode.
- Executes single-cycle ALU ops or an iterative multiply, then presents a registered result with flags under valid/ready backpressure.
- Sits between the instruction front-end and the writeback/flags logic.

Parameters:
- OPW, 16, operand width in bits (>=4, power of 2).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- instruction  input  2*OPW  A = [OPW-1:0], B = [2*OPW-1:OPW].
- op  input  4  opcode.
- in_valid  input  1  instruction/op valid.
- ready  output  1  core idle; instruction accepted on in_valid && ready at posedge.
- result  output  2*OPW  registered result.
- flags  output  4  {V, C, N, Z} = [3:0]; valid with res_valid.
- err  output  1  illegal opcode; valid with res_valid.
- res_valid  output  1  result/flags/err valid.
- res_ready  input  1  consumer accepts result.
- op_cnt  output  CNT_W  count of completed (consumed) results.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state IDLE, ready=0, result=0, flags=0, err=0, res_valid=0, op_cnt=0. ready rises at the first posedge after rst deasserts.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: ready=1. On in_valid: latch A, B, op; ready=0. Go to DONE for single-cycle ops and illegal ops, or to EXEC for MUL.
  - EXEC: shift-add multiply, one partial product per cycle, OPW cycles, then DONE.
  - DONE: res_valid=1. Outputs are held stable until res_ready. On res_valid && res_ready: op_cnt++ (wraps to 0 at 2^CNT_W), res_valid=0, go to IDLE, ready=1 the next cycle.
- Latency, acceptance edge to res_valid:
  - 1 cycle for single-cycle ops.
  - OPW+1 cycles for MUL.
- Throughput: at most 1 op per 2 cycles. No acceptance in DONE.
- Opcodes and results:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 SHL: A << B[log2(OPW)-1:0].
  - 6 SHR: A >> B[log2(OPW)-1:0], logical.
  - 7 PASS: A.
  - 8 MUL: unsigned A*B (MUL_EN only).
  - 9-15 illegal.
- Widths:
  - Non-MUL ops write result[OPW-1:0]; result[2*OPW-1:OPW] = 0.
  - MUL writes the full 2*OPW product.
- Flags:
  - Z = evaluated result field == 0.
  - N = msb of the evaluated field: bit OPW-1, or bit 2*OPW-1 for MUL.
  - C: ADD = carry-out; SUB = borrow (A<B unsigned); else 0.
  - V: ADD/SUB = signed two's-complement overflow; else 0.
- Illegal op: result=0, flags=0, err=1, 1-cycle latency. The core continues normally afterwards.
- Boundaries:
  - Shift amount 0 returns A unchanged.
  - MUL with A=0 or B=0 still takes the full OPW+1 cycles.
  - in_valid while ready=0 is ignored; the upstream must hold it.
  - rst asserted mid-EXEC or in DONE aborts immediately: the result is lost, op_cnt is cleared.
  - res_ready held low keeps DONE indefinitely with outputs frozen.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 8 = iterative unsigned multiply through EXEC, as above.
- Undefined: EXEC and the multiplier datapath are not built; opcode 8 is illegal (err=1, result=0, flags=0, 1-cycle latency).

Test Plan (OPW=16, CNT_W=8):
- Reset, then ADD A=0xFFFF B=0x0001, res_ready=1 -> res_valid 1 cycle after accept; result=0x00000000, flags={V0,C1,N0,Z1}; op_cnt=1.
- SUB A=0x8000 B=0x0001 -> result=0x00007FFF, flags={V1,C0,N0,Z0}. Then SUB A=0x0001 B=0x0002 -> result=0x0000FFFF, C=1, N=1.
- MUL A=0x1234 B=0x0010 with MUL_EN -> ready low 17 cycles; result=0x00012340, flags=0. Without the macro -> err=1, result=0 after 1 cycle.
- SHL A=0x0001 B=0x000F then SHR A=0x8000 B=0x0004 -> 0x00008000 (N=1), then 0x00000800.
- Backpressure: XOR A=0xAAAA B=0x5555 with res_ready=0 for 5 cycles -> res_valid, result=0x0000FFFF held stable; ready=0; in_valid pulses ignored; op_cnt increments only on the handshake.
- Reset mid-MUL at cycle 6 of EXEC -> all outputs 0 asynchronously. ready=1 one posedge after release. Next ADD 2+3=0x00000005 with op_cnt=1. Also 256 consecutive ops -> op_cnt wraps to 0.
